// File: rtl/trig_pkg.sv
// Shared encodings for the trigger/acquisition sequencer.
// Holds state, mode and slope constants plus saturating threshold helpers.
package trig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DISPLAY = 3'd3,
        ST_HOLDOFF = 3'd4
    } trig_state_t;

    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_NORMAL = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_STOP   = 2'b11;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : '0;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? '1 : s[7:0];
    endfunction

endpackage

// File: rtl/trig_edge_det.sv
// Level-crossing detector with hysteresis: source mux, saturating thresholds,
// primed flag and combinational fire on the qualifying sample.
module trig_edge_det #(
    parameter logic [7:0] HYST = 8'd2
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] adc_a,
    input  logic [7:0] adc_b,
    input  logic       src,
    input  logic       slope,
    input  logic [7:0] level,
    output logic       fire
);
    import trig_pkg::*;

    logic [7:0] sample;
    logic [7:0] thr_lo;
    logic [7:0] thr_hi;
    logic       primed_q;
    logic       primed_d;

    assign sample = (src == SRC_B) ? adc_b : adc_a;
    assign thr_lo = sat_sub(level, HYST);
    assign thr_hi = sat_add(level, HYST);

    // Priming needs the signal to leave the hysteresis band on the far side first.
    always_comb begin
        primed_d = primed_q;
        fire     = 1'b0;
        if (clear) begin
            primed_d = 1'b0;
        end else if (enable) begin
            if (slope == SLOPE_RISE) begin
                if (sample < thr_lo) primed_d = 1'b1;
                fire = primed_q && (sample >= level);
            end else begin
                if (sample > thr_hi) primed_d = 1'b1;
                fire = primed_q && (sample <= level);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) primed_q <= 1'b0;
        else       primed_q <= primed_d;
    end

endmodule

// File: rtl/trig_ctrl.sv
// Trigger/acquisition sequencer: arm, detect, start capture, wait for frame and
// display done, hold off, re-arm. Auto-timeout trigger present when TRIG_AUTO_EN is defined.
module trig_ctrl #(
    parameter logic [7:0]  HYST         = 8'd2,
    parameter logic [15:0] AUTO_TIMEOUT = 16'd50000,
    parameter logic [7:0]  HOLDOFF      = 8'd4
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic [7:0] adc_a,
    input  logic [7:0] adc_b,
    input  logic       trig_src,
    input  logic       trig_slope,
    input  logic [7:0] trig_level,
    input  logic [1:0] mode,
    input  logic       arm,
    input  logic       sample_ok,
    input  logic       resume_ok,
    output logic       sample_init,
    output logic       triggered,
    output logic       auto_fired,
    output logic       busy,
    output logic [2:0] state_o
);
    import trig_pkg::*;

    trig_state_t state_q, state_d;
    logic        sample_init_q, sample_init_d;
    logic        triggered_q, triggered_d;
    logic        auto_fired_q, auto_fired_d;
    logic [7:0]  ho_cnt_q, ho_cnt_d;
    logic        ok_prev_q, resume_prev_q;
    logic        enter_armed;
    logic        edge_fire;
    logic        auto_fire;

    trig_edge_det #(.HYST(HYST)) u_edge (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clear   (enter_armed),
        .enable  (sample_tick && (state_q == ST_ARMED)),
        .adc_a   (adc_a),
        .adc_b   (adc_b),
        .src     (trig_src),
        .slope   (trig_slope),
        .level   (trig_level),
        .fire    (edge_fire)
    );

`ifdef TRIG_AUTO_EN
    logic [15:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (enter_armed)
            to_cnt_d = '0;
        else if ((state_q == ST_ARMED) && sample_tick && (mode == MODE_AUTO))
            to_cnt_d = to_cnt_q + 16'd1;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end

    assign auto_fire = (state_q == ST_ARMED) && sample_tick && (mode == MODE_AUTO)
                       && (to_cnt_q == AUTO_TIMEOUT - 16'd1);
`else
    assign auto_fire = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        sample_init_d = 1'b0;
        triggered_d   = triggered_q;
        auto_fired_d  = auto_fired_q;
        ho_cnt_d      = ho_cnt_q;
        enter_armed   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((mode == MODE_AUTO) || (mode == MODE_NORMAL) || ((mode == MODE_SINGLE) && arm))
                    enter_armed = 1'b1;
            end
            ST_ARMED: begin
                if (mode == MODE_STOP) begin
                    state_d = ST_IDLE;
                end else if (edge_fire || auto_fire) begin
                    state_d       = ST_CAPTURE;
                    sample_init_d = 1'b1;
                    triggered_d   = 1'b1;
                    auto_fired_d  = auto_fire && !edge_fire;
                end
            end
            ST_CAPTURE: begin
                if (sample_ok && !ok_prev_q) state_d = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                if (resume_ok && !resume_prev_q) begin
                    state_d  = ST_HOLDOFF;
                    ho_cnt_d = '0;
                end
            end
            ST_HOLDOFF: begin
                if (ho_cnt_q == HOLDOFF) begin
                    if ((mode == MODE_SINGLE) || (mode == MODE_STOP)) state_d = ST_IDLE;
                    else                                              enter_armed = 1'b1;
                end else if (sample_tick) begin
                    ho_cnt_d = ho_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Every path into ARMED starts a fresh trigger attempt.
        if (enter_armed) begin
            state_d      = ST_ARMED;
            triggered_d  = 1'b0;
            auto_fired_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sample_init_q <= 1'b0;
            triggered_q   <= 1'b0;
            auto_fired_q  <= 1'b0;
            ho_cnt_q      <= '0;
            ok_prev_q     <= 1'b0;
            resume_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sample_init_q <= sample_init_d;
            triggered_q   <= triggered_d;
            auto_fired_q  <= auto_fired_d;
            ho_cnt_q      <= ho_cnt_d;
            ok_prev_q     <= sample_ok;
            resume_prev_q <= resume_ok;
        end
    end

    assign sample_init = sample_init_q;
    assign triggered   = triggered_q;
    assign auto_fired  = auto_fired_q;
    assign busy        = (state_q == ST_CAPTURE) || (state_q == ST_DISPLAY) || (state_q == ST_HOLDOFF);
    assign state_o     = state_q;

endmodule

// File: tb/tb_trig_ctrl.sv
// Directed bench for trig_ctrl; expectations adapt to TRIG_AUTO_EN.
module tb_trig_ctrl;
    import trig_pkg::*;

    logic       sys_clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic [7:0] adc_a = '0;
    logic [7:0] adc_b = '0;
    logic       trig_src = 1'b0;
    logic       trig_slope = 1'b0;
    logic [7:0] trig_level = 8'd128;
    logic [1:0] mode = 2'b01;
    logic       arm = 1'b0;
    logic       sample_ok = 1'b0;
    logic       resume_ok = 1'b0;
    logic       sample_init, triggered, auto_fired, busy;
    logic [2:0] state_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    trig_ctrl #(.HYST(8'd2), .AUTO_TIMEOUT(16'd16), .HOLDOFF(8'd4)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .adc_a       (adc_a),
        .adc_b       (adc_b),
        .trig_src    (trig_src),
        .trig_slope  (trig_slope),
        .trig_level  (trig_level),
        .mode        (mode),
        .arm         (arm),
        .sample_ok   (sample_ok),
        .resume_ok   (resume_ok),
        .sample_init (sample_init),
        .triggered   (triggered),
        .auto_fired  (auto_fired),
        .busy        (busy),
        .state_o     (state_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic tick(input logic [7:0] a, input logic [7:0] b);
        sample_tick = 1'b1;
        adc_a = a;
        adc_b = b;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic frame_done();
        sample_ok = 1'b1;
        step();
        sample_ok = 1'b0;
        resume_ok = 1'b1;
        step();
        resume_ok = 1'b0;
    endtask

    task automatic holdoff_exit();
        repeat (4) tick(8'd0, 8'd0);
        step();
    endtask

    initial begin
        int pulses;
        int fire_at;

        // reset state
        step();
        step();
        check("rst_state", state_o, 0);
        check("rst_init", sample_init, 0);
        check("rst_trig", triggered, 0);
        check("rst_auto", auto_fired, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        step();
        check("arm_normal", state_o, 1);

        // normal mode, rising ramp on A
        pulses = 0;
        fire_at = -1;
        for (int v = 100; v <= 200; v++) begin
            tick(8'(v), 8'd0);
            if (sample_init) begin
                pulses++;
                fire_at = v;
            end
            step();
            if (sample_init) pulses++;
        end
        check("ramp_pulses", pulses, 1);
        check("ramp_level", fire_at, 128);
        check("ramp_trig", triggered, 1);
        check("ramp_auto", auto_fired, 0);
        check("ramp_state", state_o, 2);
        sample_ok = 1'b1;
        step();
        sample_ok = 1'b0;
        check("to_display", state_o, 3);
        resume_ok = 1'b1;
        step();
        resume_ok = 1'b0;
        check("to_holdoff", state_o, 4);
        check("ho_busy", busy, 1);
        holdoff_exit();
        check("rearm_state", state_o, 1);
        check("rearm_trig", triggered, 0);

        // start above level: must dip below level-HYST first
        tick(8'd129, 8'd0);
        tick(8'd130, 8'd0);
        tick(8'd140, 8'd0);
        tick(8'd126, 8'd0);
        tick(8'd128, 8'd0);
        check("noprime_state", state_o, 1);
        check("noprime_init", sample_init, 0);
        tick(8'd125, 8'd0);
        tick(8'd128, 8'd0);
        check("prime_init", sample_init, 1);
        check("prime_state", state_o, 2);
        frame_done();
        mode = MODE_AUTO;
        holdoff_exit();
        check("auto_armed", state_o, 1);

        // auto timeout after 16 ticks
        repeat (15) tick(8'd50, 8'd0);
        check("auto_pre", state_o, 1);
        tick(8'd50, 8'd0);
`ifdef TRIG_AUTO_EN
        check("auto_init", sample_init, 1);
        check("auto_flag", auto_fired, 1);
        check("auto_state", state_o, 2);
        frame_done();
        holdoff_exit();
        check("auto_rearm", auto_fired, 0);
`else
        check("noauto_init", sample_init, 0);
        check("noauto_flag", auto_fired, 0);
        check("noauto_state", state_o, 1);
`endif
        mode = MODE_STOP;
        step();
        check("stop_armed", state_o, 0);

        // arm ignored unless single mode
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("arm_stop", state_o, 0);
        mode = MODE_SINGLE;
        trig_slope = SLOPE_FALL;
        trig_src = SRC_B;
        step();
        check("single_wait", state_o, 0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("single_arm", state_o, 1);

        // single shot, falling on B
        tick(8'd100, 8'd140);
        tick(8'd100, 8'd135);
        tick(8'd100, 8'd129);
        check("fall_pre", state_o, 1);
        tick(8'd100, 8'd128);
        check("fall_init", sample_init, 1);
        check("fall_state", state_o, 2);
        frame_done();
        check("fall_ho", state_o, 4);
        repeat (3) tick(8'd0, 8'd0);
        check("ho_3", state_o, 4);
        tick(8'd0, 8'd0);
        check("ho_4", state_o, 4);
        step();
        check("single_idle", state_o, 0);
        check("single_busy", busy, 0);
        tick(8'd100, 8'd140);
        tick(8'd100, 8'd128);
        check("idle_state", state_o, 0);
        check("idle_init", sample_init, 0);
        check("idle_trig", triggered, 1);
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("rearm_single", state_o, 1);
        check("rearm_clr", triggered, 0);

        // sample_ok high at entry is not an edge; stop during capture completes frame
        sample_ok = 1'b1;
        tick(8'd100, 8'd140);
        tick(8'd100, 8'd128);
        check("cap_entry", state_o, 2);
        mode = MODE_STOP;
        step();
        step();
        check("cap_hold", state_o, 2);
        sample_ok = 1'b0;
        step();
        sample_ok = 1'b1;
        step();
        sample_ok = 1'b0;
        check("cap_edge", state_o, 3);
        resume_ok = 1'b1;
        step();
        resume_ok = 1'b0;
        check("stop_ho", state_o, 4);
        holdoff_exit();
        check("stop_idle", state_o, 0);
        check("stop_busy", busy, 0);

        // asynchronous reset mid-display
        mode = MODE_NORMAL;
        trig_slope = SLOPE_RISE;
        trig_src = SRC_A;
        step();
        check("n_arm", state_o, 1);
        tick(8'd100, 8'd0);
        tick(8'd128, 8'd0);
        sample_ok = 1'b1;
        step();
        sample_ok = 1'b0;
        check("mid_disp", state_o, 3);
        #2 reset = 1'b1;
        #1;
        check("async_state", state_o, 0);
        check("async_trig", triggered, 0);
        check("async_busy", busy, 0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_arm", state_o, 1);
        tick(8'd100, 8'd0);
        tick(8'd128, 8'd0);
        check("post_rst_init", sample_init, 1);
        #2 reset = 1'b1;
        #1;
        check("init_cut", sample_init, 0);
        step();
        reset = 1'b0;
        step();
        check("rearm2", state_o, 1);

        // level 0 rising can never prime
        trig_level = 8'd0;
        tick(8'd0, 8'd0);
        tick(8'd10, 8'd0);
        tick(8'd255, 8'd0);
        check("lvl0", state_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
